led_frame_ctrl: RTL
===================

LED_FRAME_CTRL -- requirements
Module: led_frame_ctrl

Interface
REQ-001 SHALL have parameter BYTES_W, default 10, width of frame byte count.
REQ-002 SHALL have parameter PERIOD_W, default 8, width of bit-period count.
REQ-003 SHALL have parameter LATCH_W, default 16, width of inter-frame latch gap count.
REQ-004 SHALL have port clock  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-clock pulse that begins a frame.
REQ-007 SHALL have port abort  in  1  one-clock pulse that ends any frame immediately.
REQ-008 SHALL have port frame_bytes  in  BYTES_W  bytes per frame, sampled at start.
REQ-009 SHALL have port bit_period  in  PERIOD_W  clocks between sync toggles, sampled at start.
REQ-010 SHALL have port latch_cycles  in  LATCH_W  idle clocks after the last bit, sampled at start.
REQ-011 SHALL have port fifo_req  in  1  shifter FIFO not-full (raw DMA request).
REQ-012 SHALL have port dma_ack  in  1  one-clock pulse per byte written by DMA.
REQ-013 SHALL have port sync  out  1  bit strobe; each toggle advances the shifter one bit.
REQ-014 SHALL have port dma_req  out  1  gated DMA request.
REQ-015 SHALL have port busy  out  1  high in any state except IDLE.
REQ-016 SHALL have port frame_done  out  1  one-clock pulse at the end of LATCH.
REQ-017 SHALL have port underrun  out  1  sticky flag for a DMA starvation stall.

Function
REQ-018 SHALL implement states IDLE, FILL, RUN and LATCH.
REQ-019 IDLE: start with frame_bytes != 0 SHALL register config, clear counters and underrun, and enter FILL next cycle; start with frame_bytes == 0 SHALL be ignored.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 dma_req SHALL equal fifo_req AND (state is FILL or RUN) AND acked < frame_bytes; it is combinational from fifo_req.
REQ-022 acked counter SHALL increment on each dma_ack while acked < frame_bytes; extra acks SHALL be ignored.
REQ-023 FILL SHALL move to RUN in the cycle after acked first becomes >= 1.
REQ-024 RUN: the period counter SHALL reload to max(bit_period, 2) - 1 on entry and after each toggle; sync SHALL toggle when it reaches 0.
REQ-025 Total toggles per frame SHALL be 8 * frame_bytes, held in a (BYTES_W+3)-bit counter.
REQ-026 A toggle due while toggles == 8 * acked (and acked < frame_bytes) SHALL stall: sync holds, the period counter holds at 0, and underrun sets; the toggle SHALL fire in the cycle after the next dma_ack.
REQ-027 After the final toggle, the block SHALL enter LATCH and count latch_cycles clocks with sync constant; latch_cycles == 0 SHALL take one clock.
REQ-028 At LATCH exit, frame_done SHALL pulse for one clock in the same cycle the state returns to IDLE.
REQ-029 abort in any state SHALL return to IDLE next cycle with no frame_done; sync keeps its level; underrun is held.
REQ-030 If abort and start occur together, abort SHALL win.
REQ-031 Changes to config inputs mid-frame SHALL have no effect.

Reset
REQ-032 On reset, the block SHALL be in IDLE with sync=0, dma_req=0, busy=0, frame_done=0, underrun=0 and all counters 0.
REQ-033 Reset mid-frame SHALL take priority over abort and start.

Structure
REQ-034 State encoding and the minimum bit-period constant (2) SHALL live in shared package led_ctrl_pkg.
REQ-035 The period/latch down-counter SHALL be one sub-module, led_tick_counter, instantiated once and reused across RUN and LATCH.

Verification
REQ-036 Test: frame_bytes=2, bit_period=4, latch=10, fifo_req=1, ack every 3 clocks -> 16 sync toggles spaced 4 clocks; frame_done 10 clocks after the last toggle; underrun=0.
REQ-037 Test: frame_bytes=3, ack only the first byte -> sync stalls after 8 toggles and underrun=1; ack 2 bytes 50 clocks later -> toggles resume the cycle after each ack, 24 in total.
REQ-038 Test: bit_period=0 and bit_period=1 -> toggles spaced 2 clocks.
REQ-039 Test: abort during RUN after 5 toggles -> busy=0 next cycle, no frame_done, dma_req=0; a following start runs a full frame.
REQ-040 Test: frame_bytes=0 start, start while busy, 5 extra dma_acks -> all ignored; dma_req drops once acked == frame_bytes.
REQ-041 Test: reset asserted in LATCH -> all outputs at reset values next cycle, no frame_done.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED frame controller.
// Holds the FSM encoding and the bit-period floor.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_LATCH = 2'd3
  } led_state_e;

  localparam int unsigned MIN_PERIOD = 2;

  function automatic int unsigned clamp_min(
    input int unsigned v,
    input int unsigned lo
  );
    return (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/led_tick_counter.sv
// Loadable down-counter that parks at zero.
// Shared between bit-period timing and the latch gap.
module led_tick_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/led_frame_ctrl.sv
// LED shift-register frame controller: paces sync toggles
// against DMA byte delivery, then holds a latch gap.
module led_frame_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned BYTES_W  = 10,
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned LATCH_W  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [BYTES_W-1:0]  frame_bytes,
  input  logic [PERIOD_W-1:0] bit_period,
  input  logic [LATCH_W-1:0]  latch_cycles,
  input  logic                fifo_req,
  input  logic                dma_ack,
  output logic                sync,
  output logic                dma_req,
  output logic                busy,
  output logic                frame_done,
  output logic                underrun
);

  localparam int unsigned CNT_W =
    (PERIOD_W > LATCH_W) ? PERIOD_W : LATCH_W;
  localparam int unsigned TOG_W = BYTES_W + 3;

  led_state_e state_q;
  led_state_e state_d;

  logic [BYTES_W-1:0]  bytes_q;
  logic [BYTES_W-1:0]  bytes_d;
  logic [BYTES_W-1:0]  acked_q;
  logic [BYTES_W-1:0]  acked_d;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_d;
  logic [LATCH_W-1:0]  latch_q;
  logic [LATCH_W-1:0]  latch_d;
  logic [TOG_W-1:0]    toggles_q;
  logic [TOG_W-1:0]    toggles_d;
  logic                sync_q;
  logic                sync_d;
  logic                underrun_q;
  logic                underrun_d;
  logic                done_q;
  logic                done_d;

  logic in_idle;
  logic in_fill;
  logic in_run;
  logic in_latch;
  logic active;
  logic acked_lt;
  logic start_ok;
  logic ack_ok;
  logic fill_go;
  logic due;
  logic stall;
  logic fire;
  logic last_tog;

  logic [TOG_W-1:0] tog_avail;
  logic [TOG_W-1:0] tog_total;

  logic             tick_load;
  logic             tick_dec;
  logic             tick_zero;
  logic [CNT_W-1:0] tick_val;
  logic [CNT_W-1:0] period_rl;
  logic [CNT_W-1:0] latch_rl;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_fill  = (state_q == ST_FILL);
  assign in_run   = (state_q == ST_RUN);
  assign in_latch = (state_q == ST_LATCH);
  assign active   = in_fill || in_run;
  assign acked_lt = (acked_q < bytes_q);

  assign start_ok = start && !abort && in_idle
                 && (frame_bytes != '0);
  assign ack_ok   = active && dma_ack && acked_lt;

  // Each acked byte releases eight toggles.
  assign tog_avail = {acked_q, 3'b000};
  assign tog_total = {bytes_q, 3'b000};

  assign fill_go  = in_fill && (acked_q != '0) && !abort;
  assign due      = in_run && tick_zero && !abort;
  assign stall    = due && (toggles_q == tog_avail)
                 && acked_lt;
  assign fire     = due && !stall;
  assign last_tog = fire
                 && ((toggles_q + TOG_W'(1)) == tog_total);

  assign period_rl = CNT_W'(
    clamp_min(32'(period_q), MIN_PERIOD) - 32'd1);
  assign latch_rl  = CNT_W'(
    clamp_min(32'(latch_q), 32'd1) - 32'd1);

  assign tick_load = fill_go || fire;
  assign tick_val  = last_tog ? latch_rl : period_rl;
  assign tick_dec  = (in_run || in_latch) && !tick_zero;

  led_tick_counter #(
    .W(CNT_W)
  ) u_tick (
    .clock    (clock),
    .reset    (reset),
    .load     (tick_load),
    .dec      (tick_dec),
    .load_val (tick_val),
    .zero     (tick_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_ok)  state_d = ST_FILL;
      ST_FILL:  if (fill_go)   state_d = ST_RUN;
      ST_RUN:   if (last_tog)  state_d = ST_LATCH;
      ST_LATCH: if (tick_zero) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    bytes_d    = bytes_q;
    period_d   = period_q;
    latch_d    = latch_q;
    acked_d    = acked_q;
    toggles_d  = toggles_q;
    sync_d     = sync_q;
    underrun_d = underrun_q;
    done_d     = in_latch && tick_zero && !abort;
    if (start_ok) begin
      bytes_d    = frame_bytes;
      period_d   = bit_period;
      latch_d    = latch_cycles;
      acked_d    = '0;
      toggles_d  = '0;
      underrun_d = 1'b0;
    end
    if (ack_ok) begin
      acked_d = acked_q + 1'b1;
    end
    if (fire) begin
      toggles_d = toggles_q + 1'b1;
      sync_d    = ~sync_q;
    end
    if (stall) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bytes_q    <= '0;
      period_q   <= '0;
      latch_q    <= '0;
      acked_q    <= '0;
      toggles_q  <= '0;
      sync_q     <= 1'b0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bytes_q    <= bytes_d;
      period_q   <= period_d;
      latch_q    <= latch_d;
      acked_q    <= acked_d;
      toggles_q  <= toggles_d;
      sync_q     <= sync_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    sync       = sync_q;
    busy       = !in_idle;
    dma_req    = fifo_req && active && acked_lt;
    frame_done = done_q;
    underrun   = underrun_q;
  end

endmodule
